// File: rtl/ks_pkg.sv
// rtl/ks_pkg.sv - shared types and constants for the envelope controller
package ks_pkg;

  localparam int VOL_W = 10;
  localparam logic [VOL_W-1:0] VOL_MAX = 10'd1023;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } ks_state_e;

endpackage

// File: rtl/ks_env_ctrl_if.sv
// rtl/ks_env_ctrl_if.sv - note/config/volume bundle between voice logic and envelope
interface ks_env_ctrl_if #(
  parameter int STEP_W = 8,
  parameter int DIV_W  = 8
) ();
  import ks_pkg::*;

  logic              note_on;
  logic              note_off;
  logic [STEP_W-1:0] attack_step;
  logic [STEP_W-1:0] decay_step;
  logic [VOL_W-1:0]  sustain_level;
  logic [STEP_W-1:0] release_step;
  logic [DIV_W-1:0]  rate_div;
  logic [VOL_W-1:0]  volume;
  logic              mute;
  logic              busy;

  modport master (
    output note_on, note_off, attack_step, decay_step, sustain_level,
           release_step, rate_div,
    input  volume, mute, busy
  );

  modport slave (
    input  note_on, note_off, attack_step, decay_step, sustain_level,
           release_step, rate_div,
    output volume, mute, busy
  );

endinterface

// File: rtl/ks_tick_div.sv
// rtl/ks_tick_div.sv - sample-tick prescaler, one tick every i_div+1 enabled cycles
module ks_tick_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit  = (r_cnt == i_div);
  assign o_tick = i_en && w_hit;

  // Counter holds its value while disabled (SUSTAIN/IDLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ks_env_ctrl.sv
// rtl/ks_env_ctrl.sv - attack/decay/sustain/release volume sequencer for one voice
module ks_env_ctrl
  import ks_pkg::*;
#(
  parameter int STEP_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic         lrck,
  input  logic         rst,
  ks_env_ctrl_if.slave bus
);

  ks_state_e         r_state;
  logic [VOL_W-1:0]  r_volume;
  logic              r_mute;
  logic              r_busy;
  logic [STEP_W-1:0] r_atk_step;
  logic [STEP_W-1:0] r_dec_step;
  logic [STEP_W-1:0] r_rel_step;
  logic [VOL_W-1:0]  r_sustain;
  logic [DIV_W-1:0]  r_rate_div;

  logic             w_tick;
  logic             w_tick_en;
  logic             w_off_ok;
  logic             w_clear;
  logic [VOL_W:0]   w_atk_sum;
  logic [VOL_W:0]   w_dec_lim;
  logic [VOL_W:0]   w_vol_ext;

  assign w_tick_en = (r_state == ST_ATTACK) || (r_state == ST_DECAY) ||
                     (r_state == ST_RELEASE);
  assign w_off_ok  = bus.note_off &&
                     ((r_state == ST_ATTACK) || (r_state == ST_DECAY) ||
                      (r_state == ST_SUSTAIN));
  assign w_clear   = bus.note_on || w_off_ok;

  // One bit of headroom so the compares below cannot wrap.
  assign w_vol_ext = {1'b0, r_volume};
  assign w_atk_sum = w_vol_ext + (VOL_W+1)'(r_atk_step);
  assign w_dec_lim = {1'b0, r_sustain} + (VOL_W+1)'(r_dec_step);

  ks_tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk     (lrck),
    .rst     (rst),
    .i_clear (w_clear),
    .i_en    (w_tick_en),
    .i_div   (r_rate_div),
    .o_tick  (w_tick)
  );

  always_ff @(posedge lrck) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_volume   <= '0;
      r_mute     <= 1'b1;
      r_busy     <= 1'b0;
      r_atk_step <= '0;
      r_dec_step <= '0;
      r_rel_step <= '0;
      r_sustain  <= '0;
      r_rate_div <= '0;
    end else if (bus.note_on) begin
      // Retrigger keeps the current volume so the ramp has no click.
      r_state    <= ST_ATTACK;
      r_mute     <= 1'b0;
      r_busy     <= 1'b1;
      r_atk_step <= bus.attack_step;
      r_dec_step <= bus.decay_step;
      r_sustain  <= bus.sustain_level;
      r_rate_div <= bus.rate_div;
    end else if (w_off_ok) begin
      r_state    <= ST_RELEASE;
      r_rel_step <= bus.release_step;
    end else if (w_tick) begin
      case (r_state)
        ST_ATTACK: begin
          if ((r_atk_step == '0) || (w_atk_sum >= (VOL_W+1)'(VOL_MAX))) begin
            r_volume <= VOL_MAX;
            r_state  <= ST_DECAY;
          end else begin
            r_volume <= w_atk_sum[VOL_W-1:0];
          end
        end
        ST_DECAY: begin
          if ((r_dec_step == '0) || (w_vol_ext <= w_dec_lim)) begin
            r_volume <= r_sustain;
            r_state  <= ST_SUSTAIN;
          end else begin
            r_volume <= r_volume - VOL_W'(r_dec_step);
          end
        end
        ST_RELEASE: begin
          if ((r_rel_step == '0) || (w_vol_ext <= (VOL_W+1)'(r_rel_step))) begin
            r_volume <= '0;
            r_state  <= ST_IDLE;
            r_mute   <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_volume <= r_volume - VOL_W'(r_rel_step);
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign bus.volume = r_volume;
  assign bus.mute   = r_mute;
  assign bus.busy   = r_busy;

endmodule
